// File: rtl/pipe_stall_ctrl_pkg.sv
// pipe_stall_ctrl_pkg: stall masks and sequencer state encodings shared by the stall controller
// Stall bit order: [0]=PC [1]=IF [2]=ID [3]=EX [4]=MEM [5]=WB, 1 = stop.
package pipe_stall_ctrl_pkg;
  localparam logic [5:0] STALL_IF  = 6'b000011;
  localparam logic [5:0] STALL_ID  = 6'b000111;
  localparam logic [5:0] STALL_EX  = 6'b001111;
  localparam logic [5:0] STALL_MEM = 6'b011111;
  localparam logic [1:0] S_RUN      = 2'd0;
  localparam logic [1:0] S_MDU_WAIT = 2'd1;
  localparam logic [1:0] S_FLUSH    = 2'd2;
endpackage

// File: rtl/pipe_mdu_timer.sv
// pipe_mdu_timer: MDU hold counter with load, freeze, decrement, clear and zero flag
// Ports: clk, reset (sync, active-high); load/load_val preset the count;
//        dec counts down (dec=0 freezes); clr zeroes; zero flags count==0.
module pipe_mdu_timer #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  input  logic             clr,
  output logic             zero
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk)
    if (reset || clr) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec) cnt <= cnt - CNT_W'(1);
  assign zero = cnt == '0;
endmodule

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: pipeline sequencer merging stage stalls, timing MUL/DIV in EX and flushing on exceptions
// Ports: clk, reset (sync, active-high); if_req/id_req/mem_req stage waits;
//        ex_mdu_start/ex_mdu_div MDU op held in EX; exc_valid/exc_target exception from MEM;
//        stall[5:0] per-stage stop; flush/flush_pc redirect; mdu_done result pulse; mdu_busy.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 33,
  parameter int CNT_W   = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic        id_req,
  input  logic        ex_mdu_start,
  input  logic        ex_mdu_div,
  input  logic        mem_req,
  input  logic        exc_valid,
  input  logic [31:0] exc_target,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] flush_pc,
  output logic        mdu_done,
  output logic        mdu_busy
);
  logic [1:0] state, state_nxt;
  logic [31:0] flush_pc_q;
  logic [CNT_W-1:0] lat_m1;
  logic in_run, in_wait, in_flush, take_exc, accept, adv, dec, done, zero;
  logic [5:0] stall_c;
  assign in_run   = state == S_RUN;
  assign in_wait  = state == S_MDU_WAIT;
  assign in_flush = state == S_FLUSH;
  // an exception in FLUSH belongs to an already-flushed MEM stage
  assign take_exc = !in_flush && exc_valid;
  // a start under a MEM wait is retried next cycle, the op is still sitting in EX
  assign accept   = in_run && ex_mdu_start && !mem_req && !exc_valid;
  assign adv      = in_wait && !exc_valid && !mem_req;
  assign dec      = adv && !zero;
  assign done     = adv && zero;
  assign lat_m1   = ex_mdu_div ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
  pipe_mdu_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .load_val (lat_m1),
    .dec      (dec),
    .clr      (in_wait && exc_valid),
    .zero     (zero)
  );
  always_comb begin
    stall_c = in_flush ? 6'b0 :
              (if_req ? STALL_IF : 6'b0) | (id_req ? STALL_ID : 6'b0) |
              ((accept || dec) ? STALL_EX : 6'b0) | ((mem_req || exc_valid) ? STALL_MEM : 6'b0);
    state_nxt = take_exc ? S_FLUSH : (accept || (in_wait && !done)) ? S_MDU_WAIT : S_RUN;
  end
  always_ff @(posedge clk)
    if (reset) begin
      state      <= S_RUN;
      flush_pc_q <= '0;
    end else begin
      state <= state_nxt;
      if (take_exc) flush_pc_q <= exc_target;
    end
  assign stall    = reset ? 6'b0 : stall_c;
  assign flush    = !reset && in_flush;
  assign flush_pc = reset ? 32'b0 : flush_pc_q;
  assign mdu_done = !reset && done;
  assign mdu_busy = !reset && in_wait;
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: randomized and directed check of pipe_stall_ctrl against a cycle-level reference model
module tb_pipe_stall_ctrl;
  logic clk = 1'b0;
  logic reset, if_req, id_req, ex_mdu_start, ex_mdu_div, mem_req, exc_valid;
  logic [31:0] exc_target, flush_pc;
  logic [5:0] stall;
  logic flush, mdu_done, mdu_busy;
  int n_chk = 0, n_pass = 0;
  bit m_busy, m_fl;
  int m_served, m_lat;
  logic [31:0] m_fpc;
  pipe_stall_ctrl #(.MUL_LAT(2), .DIV_LAT(33), .CNT_W(6)) dut (
    .clk          (clk),
    .reset        (reset),
    .if_req       (if_req),
    .id_req       (id_req),
    .ex_mdu_start (ex_mdu_start),
    .ex_mdu_div   (ex_mdu_div),
    .mem_req      (mem_req),
    .exc_valid    (exc_valid),
    .exc_target   (exc_target),
    .stall        (stall),
    .flush        (flush),
    .flush_pc     (flush_pc),
    .mdu_done     (mdu_done),
    .mdu_busy     (mdu_busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
  endtask
  task automatic step(input bit r, input bit i, input bit d, input bit s, input bit dv,
                      input bit m, input bit e, input logic [31:0] t);
    int lvl;
    bit acc, adv, hold, done;
    @(negedge clk);
    reset = r; if_req = i; id_req = d; ex_mdu_start = s; ex_mdu_div = dv;
    mem_req = m; exc_valid = e; exc_target = t;
    #1;
    if (r) begin
      chk("rst_stall", {26'b0, stall}, 0);
      chk("rst_flush", {31'b0, flush}, 0);
      chk("rst_pc", flush_pc, 0);
      chk("rst_done", {31'b0, mdu_done}, 0);
      chk("rst_busy", {31'b0, mdu_busy}, 0);
      m_busy = 0; m_fl = 0; m_fpc = 0;
    end else if (m_fl) begin
      chk("fl_stall", {26'b0, stall}, 0);
      chk("fl_flush", {31'b0, flush}, 1);
      chk("fl_pc", flush_pc, m_fpc);
      chk("fl_done", {31'b0, mdu_done}, 0);
      chk("fl_busy", {31'b0, mdu_busy}, 0);
      m_fl = 0;
    end else begin
      acc  = !m_busy && s && !m && !e;
      adv  = m_busy && !e && !m;
      hold = acc || (adv && m_served < m_lat);
      done = adv && m_served >= m_lat;
      lvl = 0;
      if (i) lvl = 2;
      if (d) lvl = 3;
      if (hold) lvl = 4;
      if (m || e) lvl = 5;
      chk("stall", {26'b0, stall}, (32'd1 << lvl) - 32'd1);
      chk("flush", {31'b0, flush}, 0);
      chk("done", {31'b0, mdu_done}, {31'b0, done});
      chk("busy", {31'b0, mdu_busy}, {31'b0, m_busy});
      if (e) begin
        m_fl = 1; m_fpc = t; m_busy = 0;
      end else if (acc) begin
        m_busy = 1; m_lat = dv ? 33 : 2; m_served = 1;
      end else if (adv) begin
        if (done) m_busy = 0;
        else m_served++;
      end
    end
  endtask
  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic run_op(input string tag, input bit dv, input int mem_at, input int mem_len, input int exp_cyc);
    int k;
    for (k = 0; k < 100; k++) begin
      step(0, 0, 0, 1, dv, (k >= mem_at) && (k < mem_at + mem_len), 0, 0);
      if (mdu_done) break;
    end
    chk(tag, k + 1, exp_cyc);
    idle();
  endtask
  initial begin
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 1, 1, 1, 1, 32'hdead_beef);
    idle();
    step(0, 1, 0, 0, 0, 0, 0, 0);
    chk("if_mask", {26'b0, stall}, 32'h03);
    idle();
    chk("if_release", {26'b0, stall}, 0);
    step(0, 1, 1, 0, 0, 0, 0, 0);
    chk("if_id_mask", {26'b0, stall}, 32'h07);
    step(0, 1, 1, 0, 0, 1, 0, 0);
    chk("if_id_mem_mask", {26'b0, stall}, 32'h1f);
    idle();
    run_op("mul_lat", 0, 100, 0, 3);
    run_op("div_lat", 1, 100, 0, 34);
    run_op("div_mem_freeze", 1, 5, 3, 37);
    run_op("mul_mem_freeze", 0, 1, 3, 6);
    for (int k = 0; k < 6; k++) step(0, 0, 0, 1, 1, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0, 1, 32'hbfc0_0380);
    chk("exc_stall", {26'b0, stall}, 32'h1f);
    chk("exc_no_done", {31'b0, mdu_done}, 0);
    step(0, 1, 1, 0, 0, 1, 1, 32'h1234_5678);
    chk("exc_flush", {31'b0, flush}, 1);
    chk("exc_pc", flush_pc, 32'hbfc0_0380);
    chk("exc_flush_stall", {26'b0, stall}, 0);
    idle();
    chk("exc_run_flush", {31'b0, flush}, 0);
    chk("exc_run_busy", {31'b0, mdu_busy}, 0);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 1, 1, 0, 0, 0);
    step(1, 0, 0, 1, 1, 0, 0, 0);
    chk("rst_mid_busy", {31'b0, mdu_busy}, 0);
    run_op("mul_after_rst", 0, 100, 0, 3);
    step(0, 0, 0, 0, 0, 0, 1, 32'h8000_0180);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_mid_flush", {31'b0, flush}, 0);
    idle();
    chk("rst_flush_gone", {31'b0, flush}, 0);
    for (int k = 0; k < 4000; k++)
      step($urandom_range(0, 199) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
           m_busy || ($urandom_range(0, 2) == 0), $urandom_range(0, 3) == 0,
           $urandom_range(0, 6) == 0, $urandom_range(0, 49) == 0, $urandom);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
